toy_bus_mem_mst_pipe: RTL and testbench

Parametrised ToyBus-to-SRAM master node. It accepts ToyBusReq beats, drives a synchronous memory port with configurable read latency, and returns ToyBusAck beats through an ack FIFO. That FIFO honours backpressure on the ack channel, which the fixed one-cycle DTCM node cannot do. It sits at the memory side of the bus network, in front of DTCM/ITCM-class SRAMs with multi-cycle read pipelines.

---
 rtl/toy_bus_pkg.sv | 14 +
 rtl/toy_bus_sync_fifo.sv | 63 ++++++
 rtl/toy_bus_mem_mst_pipe.sv | 152 +++++++++++++++
 tb/tb_toy_bus_mem_mst_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_bus_pkg.sv
// ToyBus shared opcode constants and ack-entry sizing helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package toy_bus_pkg;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Ack entry is packed as {opcode, data, sideband, src_id}, MSB first.
    function automatic int ack_entry_w(input int data_w, input int sb_w, input int id_w);
        return 1 + data_w + sb_w + id_w;
    endfunction

endpackage

// File: rtl/toy_bus_sync_fifo.sv
// Generic in-order synchronous FIFO with registered occupancy.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push is ignored when full, pop is ignored when empty.
module toy_bus_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    assign o_head_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/toy_bus_mem_mst_pipe.sv
// ToyBus request to synchronous SRAM master with RD_LAT tag pipe and credited ack FIFO.
// Latency: ack valid RD_LAT+1 cycles after acceptance into an empty FIFO.
// Backpressure: requests stall while ACK_DEPTH ack credits are outstanding.
module toy_bus_mem_mst_pipe
    import toy_bus_pkg::*;
#(
    parameter int          DATA_W    = 256,
    parameter int          ADDR_W    = 32,
    parameter int          ADDR_HI   = 28,
    parameter int          SB_W      = 10,
    parameter int          ID_W      = 4,
    parameter int          RD_LAT    = 1,
    parameter int          ACK_DEPTH = 4,
    parameter bit          WR_ACK    = 1'b0,
    parameter logic [3:0]  NODE_ID   = 4'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in0_req_vld,
    output logic                in0_req_rdy,
    input  logic [ADDR_W-1:0]   in0_req_addr,
    input  logic [DATA_W/8-1:0] in0_req_strb,
    input  logic [DATA_W-1:0]   in0_req_data,
    input  logic                in0_req_opcode,
    input  logic [ID_W-1:0]     in0_req_src_id,
    input  logic [ID_W-1:0]     in0_req_tgt_id,
    input  logic [SB_W-1:0]     in0_req_sideband,
    output logic                in0_ack_vld,
    input  logic                in0_ack_rdy,
    output logic                in0_ack_opcode,
    output logic [DATA_W-1:0]   in0_ack_data,
    output logic [SB_W-1:0]     in0_ack_sideband,
    output logic [ID_W-1:0]     in0_ack_src_id,
    output logic [ID_W-1:0]     in0_ack_tgt_id,
    output logic                out0_mem_en,
    output logic                out0_mem_wr_en,
    output logic [ADDR_W-1:0]   out0_mem_addr,
    output logic [DATA_W-1:0]   out0_mem_wr_data,
    output logic [DATA_W/8-1:0] out0_mem_wr_byte_en,
    output logic [SB_W-1:0]     out0_mem_req_sideband,
    input  logic [DATA_W-1:0]   out0_mem_rd_data,
    input  logic [SB_W-1:0]     out0_mem_ack_sideband
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(ACK_DEPTH + 1);
    localparam int ACK_W  = ack_entry_w(DATA_W, SB_W, ID_W);

    typedef struct packed {
        logic              opcode;
        logic [DATA_W-1:0] data;
        logic [SB_W-1:0]   sideband;
        logic [ID_W-1:0]   src_id;
    } ack_ent_t;

    logic              w_acc;
    logic              w_ack_gen;
    logic              w_tag_ld;
    logic              w_pop;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [ACK_W-1:0]  w_push_dat;
    logic [ACK_W-1:0]  w_head_dat;
    ack_ent_t          w_push_ent;
    ack_ent_t          w_head;
    logic              w_unused;

    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_op;
    logic [ID_W-1:0]   r_tag_src [RD_LAT];
    logic [CNT_W-1:0]  r_cnt;

    assign in0_req_rdy = (r_cnt < CNT_W'(ACK_DEPTH));
    assign w_acc       = in0_req_vld & in0_req_rdy;
    assign w_ack_gen   = (in0_req_opcode == OP_RD) | WR_ACK;
    assign w_tag_ld    = w_acc & w_ack_gen;

    assign out0_mem_en           = w_acc;
    assign out0_mem_wr_en        = in0_req_opcode;
    assign out0_mem_addr         = ADDR_W'(in0_req_addr[ADDR_HI:OFF]);
    assign out0_mem_wr_data      = in0_req_data;
    assign out0_mem_wr_byte_en   = in0_req_strb;
    assign out0_mem_req_sideband = in0_req_sideband;

    // Tags ride alongside the SRAM read pipeline so the last stage lines up with rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            r_tag_op  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_src[i] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_tag_ld;
            r_tag_op[0]  <= in0_req_opcode;
            r_tag_src[0] <= in0_req_src_id;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_op[i]  <= r_tag_op[i-1];
                r_tag_src[i] <= r_tag_src[i-1];
            end
        end
    end

    assign w_push_ent.opcode   = r_tag_op[RD_LAT-1];
    assign w_push_ent.data     = r_tag_op[RD_LAT-1] ? '0 : out0_mem_rd_data;
    assign w_push_ent.sideband = out0_mem_ack_sideband;
    assign w_push_ent.src_id   = r_tag_src[RD_LAT-1];
    assign w_push_dat          = w_push_ent;

    toy_bus_sync_fifo #(
        .DEPTH (ACK_DEPTH),
        .WIDTH (ACK_W)
    ) u_ack_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (r_tag_vld[RD_LAT-1]),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    assign w_head = ack_ent_t'(w_head_dat);
    assign w_pop  = in0_ack_vld & in0_ack_rdy;

    // Credits cover both in-flight tags and queued acks, so a push can never see a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            case ({w_tag_ld, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign in0_ack_vld      = ~w_fifo_empty;
    assign in0_ack_opcode   = w_head.opcode;
    assign in0_ack_data     = w_head.data;
    assign in0_ack_sideband = w_head.sideband;
    assign in0_ack_src_id   = in0_ack_vld ? ID_W'(NODE_ID) : '0;
    assign in0_ack_tgt_id   = w_head.src_id;

    assign w_unused = ^{in0_req_tgt_id, in0_req_addr[ADDR_W-1:ADDR_HI+1],
                        in0_req_addr[OFF-1:0], w_fifo_full};

endmodule

// File: tb/tb_toy_bus_mem_mst_pipe.sv
// Directed bench for toy_bus_mem_mst_pipe with RD_LAT=2, ACK_DEPTH=4, WR_ACK=0 and WR_ACK=1 instances.
// Latency: n/a. Backpressure: driven via ack_rdy.
module tb_toy_bus_mem_mst_pipe;

    localparam int DW  = 256;
    localparam int AW  = 32;
    localparam int SBW = 10;
    localparam int IDW = 4;
    localparam int SW  = DW / 8;

    logic           clk;
    logic           rst_n;
    logic           req_vld;
    logic [AW-1:0]  req_addr;
    logic [SW-1:0]  req_strb;
    logic [DW-1:0]  req_data;
    logic           req_opcode;
    logic [IDW-1:0] req_src_id;
    logic [IDW-1:0] req_tgt_id;
    logic [SBW-1:0] req_sb;
    logic           ack_rdy;
    logic [DW-1:0]  mem_rd_data;
    logic [SBW-1:0] mem_ack_sb;

    logic           d0_req_rdy, d0_ack_vld, d0_ack_opcode;
    logic [DW-1:0]  d0_ack_data;
    logic [SBW-1:0] d0_ack_sb;
    logic [IDW-1:0] d0_ack_src, d0_ack_tgt;
    logic           d0_mem_en, d0_mem_wr_en;
    logic [AW-1:0]  d0_mem_addr;
    logic [DW-1:0]  d0_mem_wr_data;
    logic [SW-1:0]  d0_mem_be;
    logic [SBW-1:0] d0_mem_req_sb;

    logic           d1_unused_req_rdy, d1_ack_vld, d1_ack_opcode;
    logic [DW-1:0]  d1_ack_data;
    logic [SBW-1:0] d1_unused_ack_sb;
    logic [IDW-1:0] d1_unused_ack_src, d1_ack_tgt;
    logic           d1_unused_mem_en, d1_unused_mem_wr_en;
    logic [AW-1:0]  d1_unused_mem_addr;
    logic [DW-1:0]  d1_unused_mem_wr_data;
    logic [SW-1:0]  d1_unused_mem_be;
    logic [SBW-1:0] d1_unused_mem_req_sb;

    logic [DW-1:0]  m_dat1, m_dat2;
    logic [SBW-1:0] m_sb1, m_sb2;

    int checks   = 0;
    int failures = 0;

    toy_bus_mem_mst_pipe #(
        .DATA_W(DW), .ADDR_W(AW), .ADDR_HI(28), .SB_W(SBW), .ID_W(IDW),
        .RD_LAT(2), .ACK_DEPTH(4), .WR_ACK(1'b0), .NODE_ID(4'd0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in0_req_vld(req_vld), .in0_req_rdy(d0_req_rdy), .in0_req_addr(req_addr),
        .in0_req_strb(req_strb), .in0_req_data(req_data), .in0_req_opcode(req_opcode),
        .in0_req_src_id(req_src_id), .in0_req_tgt_id(req_tgt_id), .in0_req_sideband(req_sb),
        .in0_ack_vld(d0_ack_vld), .in0_ack_rdy(ack_rdy), .in0_ack_opcode(d0_ack_opcode),
        .in0_ack_data(d0_ack_data), .in0_ack_sideband(d0_ack_sb),
        .in0_ack_src_id(d0_ack_src), .in0_ack_tgt_id(d0_ack_tgt),
        .out0_mem_en(d0_mem_en), .out0_mem_wr_en(d0_mem_wr_en), .out0_mem_addr(d0_mem_addr),
        .out0_mem_wr_data(d0_mem_wr_data), .out0_mem_wr_byte_en(d0_mem_be),
        .out0_mem_req_sideband(d0_mem_req_sb), .out0_mem_rd_data(mem_rd_data),
        .out0_mem_ack_sideband(mem_ack_sb)
    );

    toy_bus_mem_mst_pipe #(
        .DATA_W(DW), .ADDR_W(AW), .ADDR_HI(28), .SB_W(SBW), .ID_W(IDW),
        .RD_LAT(2), .ACK_DEPTH(4), .WR_ACK(1'b1), .NODE_ID(4'd0)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in0_req_vld(req_vld), .in0_req_rdy(d1_unused_req_rdy), .in0_req_addr(req_addr),
        .in0_req_strb(req_strb), .in0_req_data(req_data), .in0_req_opcode(req_opcode),
        .in0_req_src_id(req_src_id), .in0_req_tgt_id(req_tgt_id), .in0_req_sideband(req_sb),
        .in0_ack_vld(d1_ack_vld), .in0_ack_rdy(ack_rdy), .in0_ack_opcode(d1_ack_opcode),
        .in0_ack_data(d1_ack_data), .in0_ack_sideband(d1_unused_ack_sb),
        .in0_ack_src_id(d1_unused_ack_src), .in0_ack_tgt_id(d1_ack_tgt),
        .out0_mem_en(d1_unused_mem_en), .out0_mem_wr_en(d1_unused_mem_wr_en),
        .out0_mem_addr(d1_unused_mem_addr), .out0_mem_wr_data(d1_unused_mem_wr_data),
        .out0_mem_wr_byte_en(d1_unused_mem_be), .out0_mem_req_sideband(d1_unused_mem_req_sb),
        .out0_mem_rd_data(mem_rd_data), .out0_mem_ack_sideband(mem_ack_sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed SRAM model with a two-cycle read pipeline; writes return junk data.
    function automatic logic [DW-1:0] word_dat(input logic [AW-1:0] w);
        return {8{w ^ 32'h5A5A_0000}};
    endfunction

    always @(posedge clk) begin
        m_dat1 <= (d0_mem_en && !d0_mem_wr_en) ? word_dat(d0_mem_addr) : {8{32'hDEAD_BEEF}};
        m_sb1  <= d0_mem_req_sb;
        m_dat2 <= m_dat1;
        m_sb2  <= m_sb1;
    end
    assign mem_rd_data = m_dat2;
    assign mem_ack_sb  = m_sb2;

    function automatic logic [AW-1:0] rd_addr(input int i, input int base);
        return AW'(base + i * 32);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_vld    = 1'b0;
        req_addr   = '0;
        req_strb   = '0;
        req_data   = '0;
        req_opcode = 1'b0;
        req_src_id = '0;
        req_tgt_id = '0;
        req_sb     = '0;
    endtask

    task automatic drive_read(input logic [AW-1:0] a, input logic [IDW-1:0] src,
                              input logic [SBW-1:0] sb);
        req_vld    = 1'b1;
        req_addr   = a;
        req_strb   = '0;
        req_data   = '0;
        req_opcode = 1'b0;
        req_src_id = src;
        req_tgt_id = 4'd9;
        req_sb     = sb;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        ack_rdy = 1'b0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (d0_req_rdy !== 1'b1) begin failures++; $display("FAIL rst_req_rdy got=%b exp=1", d0_req_rdy); end
        checks++; if (d0_ack_vld !== 1'b0) begin failures++; $display("FAIL rst_ack_vld got=%b exp=0", d0_ack_vld); end
        checks++; if (d0_ack_data !== '0) begin failures++; $display("FAIL rst_ack_data got=%h exp=0", d0_ack_data); end
        checks++; if ({d0_ack_opcode, d0_ack_sb, d0_ack_src, d0_ack_tgt} !== '0) begin
            failures++; $display("FAIL rst_ack_fields got=%h exp=0", {d0_ack_opcode, d0_ack_sb, d0_ack_src, d0_ack_tgt}); end
        checks++; if (d0_mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", d0_mem_en); end
    endtask

    task automatic test_single_read();
        do_reset();
        ack_rdy = 1'b1;
        next_cycle();
        drive_read(32'h40, 4'd3, 10'h011);
        @(negedge clk);
        checks++; if (d0_mem_en !== 1'b1) begin failures++; $display("FAIL sr_mem_en got=%b exp=1", d0_mem_en); end
        checks++; if (d0_mem_addr !== 32'h2) begin failures++; $display("FAIL sr_mem_addr got=%h exp=2", d0_mem_addr); end
        checks++; if (d0_mem_wr_en !== 1'b0) begin failures++; $display("FAIL sr_wr_en got=%b exp=0", d0_mem_wr_en); end
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            drive_idle();
            @(negedge clk);
            if (k == 1) begin
                checks++; if (d0_mem_en !== 1'b0) begin failures++; $display("FAIL sr_mem_en_1cyc got=%b exp=0", d0_mem_en); end
            end
            checks++; if (d0_ack_vld !== (k == 3)) begin failures++; $display("FAIL sr_ack_vld_c%0d got=%b exp=%b", k, d0_ack_vld, (k == 3)); end
            if (k == 3) begin
                checks++; if (d0_ack_data !== word_dat(32'h2)) begin failures++; $display("FAIL sr_ack_data got=%h exp=%h", d0_ack_data, word_dat(32'h2)); end
                checks++; if (d0_ack_tgt !== 4'd3) begin failures++; $display("FAIL sr_ack_tgt got=%0d exp=3", d0_ack_tgt); end
                checks++; if (d0_ack_opcode !== 1'b0) begin failures++; $display("FAIL sr_ack_op got=%b exp=0", d0_ack_opcode); end
                checks++; if (d0_ack_src !== 4'd0) begin failures++; $display("FAIL sr_ack_src got=%0d exp=0", d0_ack_src); end
                checks++; if (d0_ack_sb !== 10'h011) begin failures++; $display("FAIL sr_ack_sb got=%h exp=011", d0_ack_sb); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        do_reset();
        ack_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            next_cycle();
            if (c < 8) drive_read(rd_addr(c, 'h100), IDW'(c), SBW'(c + 'h20));
            else       drive_idle();
            @(negedge clk);
            if (c < 8) begin
                checks++; if (d0_req_rdy !== 1'b1) begin failures++; $display("FAIL b2b_rdy_c%0d got=%b exp=1", c, d0_req_rdy); end
            end
            checks++; if (d0_ack_vld !== (c >= 3 && c < 11)) begin
                failures++; $display("FAIL b2b_ack_vld_c%0d got=%b exp=%b", c, d0_ack_vld, (c >= 3 && c < 11)); end
            if (d0_ack_vld === 1'b1 && c >= 3 && c < 11) begin
                checks++; if (d0_ack_data !== word_dat(rd_addr(n, 'h100) >> 5) || d0_ack_tgt !== IDW'(n)) begin
                    failures++; $display("FAIL b2b_ack%0d got=%h/%0d exp=%h/%0d", n, d0_ack_data[31:0], d0_ack_tgt,
                                         word_dat(rd_addr(n, 'h100) >> 5) & 256'hFFFF_FFFF, n); end
                n++;
            end
        end
        checks++; if (n != 8) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=8", n); end
    endtask

    task automatic test_backpressure();
        int idx;
        int n;
        idx = 0;
        n   = 0;
        do_reset();
        ack_rdy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            drive_read(rd_addr(idx, 'h200), IDW'(idx), SBW'(idx));
            @(negedge clk);
            checks++; if (d0_req_rdy !== (c < 4)) begin failures++; $display("FAIL bp_rdy_c%0d got=%b exp=%b", c, d0_req_rdy, (c < 4)); end
            if (c >= 8) begin
                checks++; if (d0_ack_vld !== 1'b1 || d0_ack_data !== word_dat(rd_addr(0, 'h200) >> 5)) begin
                    failures++; $display("FAIL bp_hold_c%0d got=%b/%h", c, d0_ack_vld, d0_ack_data[31:0]); end
            end
            if (d0_req_rdy === 1'b1) idx++;
        end
        checks++; if (idx != 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", idx); end
        for (int c = 0; c < 8; c++) begin
            next_cycle();
            ack_rdy = 1'b1;
            if (idx < 6) drive_read(rd_addr(idx, 'h200), IDW'(idx), SBW'(idx));
            else         drive_idle();
            @(negedge clk);
            checks++; if (d0_req_rdy !== (c != 0)) begin failures++; $display("FAIL bp_rel_rdy_c%0d got=%b exp=%b", c, d0_req_rdy, (c != 0)); end
            if (c == 0) begin
                checks++; if (d0_mem_en !== 1'b0) begin failures++; $display("FAIL bp_full_mem_en got=%b exp=0", d0_mem_en); end
            end
            checks++; if (d0_ack_vld !== (c < 6)) begin failures++; $display("FAIL bp_ack_vld_c%0d got=%b exp=%b", c, d0_ack_vld, (c < 6)); end
            if (d0_ack_vld === 1'b1 && c < 6) begin
                checks++; if (d0_ack_data !== word_dat(rd_addr(n, 'h200) >> 5) || d0_ack_tgt !== IDW'(n)) begin
                    failures++; $display("FAIL bp_order_ack%0d got=%h/%0d exp_tgt=%0d", n, d0_ack_data[31:0], d0_ack_tgt, n); end
                n++;
            end
            if (req_vld && d0_req_rdy === 1'b1) idx++;
        end
        checks++; if (n != 6) begin failures++; $display("FAIL bp_ack_count got=%0d exp=6", n); end
    endtask

    task automatic test_write();
        do_reset();
        ack_rdy = 1'b1;
        next_cycle();
        req_vld    = 1'b1;
        req_opcode = 1'b1;
        req_addr   = 32'h80;
        req_strb   = 32'hF;
        req_data   = {8{32'h1234_5678}};
        req_src_id = 4'd5;
        req_sb     = 10'h03C;
        @(negedge clk);
        checks++; if (d0_mem_en !== 1'b1 || d0_mem_wr_en !== 1'b1) begin
            failures++; $display("FAIL wr_en got=%b/%b exp=1/1", d0_mem_en, d0_mem_wr_en); end
        checks++; if (d0_mem_be !== 32'hF || d0_mem_addr !== 32'h4) begin
            failures++; $display("FAIL wr_be_addr got=%h/%h exp=f/4", d0_mem_be, d0_mem_addr); end
        checks++; if (d0_mem_wr_data !== {8{32'h1234_5678}} || d0_mem_req_sb !== 10'h03C) begin
            failures++; $display("FAIL wr_data_sb got=%h/%h", d0_mem_wr_data[31:0], d0_mem_req_sb); end
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            drive_idle();
            @(negedge clk);
            checks++; if (d0_ack_vld !== 1'b0) begin failures++; $display("FAIL wr_noack_c%0d got=%b exp=0", k, d0_ack_vld); end
            checks++; if (d1_ack_vld !== (k == 3)) begin failures++; $display("FAIL wrack_vld_c%0d got=%b exp=%b", k, d1_ack_vld, (k == 3)); end
            if (k == 3) begin
                checks++; if (d1_ack_opcode !== 1'b1 || d1_ack_data !== '0 || d1_ack_tgt !== 4'd5) begin
                    failures++; $display("FAIL wrack_fields got=%b/%h/%0d exp=1/0/5", d1_ack_opcode, d1_ack_data[31:0], d1_ack_tgt); end
            end
        end
        ack_rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            req_vld    = 1'b1;
            req_opcode = 1'b1;
            req_addr   = rd_addr(c, 'h400);
            req_strb   = 32'hF;
            @(negedge clk);
            checks++; if (d0_req_rdy !== 1'b1) begin failures++; $display("FAIL wr_nocredit_c%0d got=%b exp=1", c, d0_req_rdy); end
        end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        ack_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            drive_read(rd_addr(c, 'h600), IDW'(c), SBW'(c));
        end
        next_cycle();
        drive_idle();
        checks++; if (d0_ack_vld !== 1'b1) begin failures++; $display("FAIL mid_pre_ack_vld got=%b exp=1", d0_ack_vld); end
        rst_n = 1'b0;
        #1;
        checks++; if (d0_ack_vld !== 1'b0) begin failures++; $display("FAIL mid_rst_ack_vld got=%b exp=0", d0_ack_vld); end
        checks++; if (d0_req_rdy !== 1'b1) begin failures++; $display("FAIL mid_rst_rdy got=%b exp=1", d0_req_rdy); end
        repeat (2) next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            @(negedge clk);
            checks++; if (d0_ack_vld !== 1'b0 || d0_req_rdy !== 1'b1) begin
                failures++; $display("FAIL mid_stale_c%0d vld=%b rdy=%b exp=0/1", k, d0_ack_vld, d0_req_rdy); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_backpressure();
        test_write();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
